// File: rtl/fft8_result_streamer_pkg.sv
// Shared constants for the 8-point FFT datapath and its result streamer.
//   FFT_N / FFT_LOG2N : transform size and index width
//   bitrev3()         : 3-bit index bit reversal (0,4,2,6,1,5,3,7 order)
//   bank_state_t      : occupancy of one frame bank
//   rd_state_t        : read-side streaming FSM state
package fft8_result_streamer_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/fft8_result_streamer_if.sv
// Output stream of the FFT result streamer: one complex bin per beat.
//   m_valid_o / m_ready_i : valid/ready handshake
//   m_re_o / m_im_o       : real / imaginary word of the beat
//   m_idx_o               : bin index of the beat
//   m_last_o              : final beat of a frame
// master = streamer side, slave = downstream consumer.
interface fft8_result_streamer_if #(
    parameter int DATA_W = 16
);
    import fft8_result_streamer_pkg::*;

    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [DATA_W-1:0]    m_re_o;
    logic [DATA_W-1:0]    m_im_o;
    logic [FFT_LOG2N-1:0] m_idx_o;
    logic                 m_last_o;

    modport master (
        output m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/fft8_frame_bank.sv
// One frame of FFT results: 8 complex words held in registers.
//   clk           : clock
//   we            : write all 8 bins this cycle
//   wr_re / wr_im : the 8 real / imaginary words to store
//   rd_idx        : bin to read
//   rd_re / rd_im : combinational read of bin rd_idx
// Contents are data-path only and carry no reset; the owner qualifies
// the read with its own valid state.
module fft8_frame_bank
    import fft8_result_streamer_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DATA_W-1:0]    wr_re [FFT_N],
    input  logic [DATA_W-1:0]    wr_im [FFT_N],
    input  logic [FFT_LOG2N-1:0] rd_idx,
    output logic [DATA_W-1:0]    rd_re,
    output logic [DATA_W-1:0]    rd_im
);

    logic [DATA_W-1:0] re_reg [FFT_N];
    logic [DATA_W-1:0] im_reg [FFT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < FFT_N; i++) begin
                re_reg[i] <= wr_re[i];
                im_reg[i] <= wr_im[i];
            end
        end
    end

    assign rd_re = re_reg[rd_idx];
    assign rd_im = im_reg[rd_idx];

endmodule

// File: rtl/fft8_result_streamer.sv
// Captures the 8 parallel complex FFT results on valid_i into one of two
// ping-pong frame banks and streams them out one bin per beat.
//   clk, rst            : clock, synchronous active-high reset
//   valid_i             : datapath results valid this cycle
//   X_k_R_i / X_k_I_i   : real / imag word of bin k (k = 0..7)
//   m                   : output stream (master side)
//   busy_o              : at least one bank holds a frame
//   ovf_o / ovf_clr_i   : sticky frame-dropped flag and its clear
module fft8_result_streamer
    import fft8_result_streamer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BITREV_OUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] X_0_R_i, X_0_I_i,
    input  logic [DATA_W-1:0] X_1_R_i, X_1_I_i,
    input  logic [DATA_W-1:0] X_2_R_i, X_2_I_i,
    input  logic [DATA_W-1:0] X_3_R_i, X_3_I_i,
    input  logic [DATA_W-1:0] X_4_R_i, X_4_I_i,
    input  logic [DATA_W-1:0] X_5_R_i, X_5_I_i,
    input  logic [DATA_W-1:0] X_6_R_i, X_6_I_i,
    input  logic [DATA_W-1:0] X_7_R_i, X_7_I_i,
    fft8_result_streamer_if.master m,
    output logic              busy_o,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);

    logic [DATA_W-1:0] cap_re [FFT_N];
    logic [DATA_W-1:0] cap_im [FFT_N];

    assign cap_re = '{X_0_R_i, X_1_R_i, X_2_R_i, X_3_R_i,
                      X_4_R_i, X_5_R_i, X_6_R_i, X_7_R_i};
    assign cap_im = '{X_0_I_i, X_1_I_i, X_2_I_i, X_3_I_i,
                      X_4_I_i, X_5_I_i, X_6_I_i, X_7_I_i};

    bank_state_t          bank_state_reg [2];
    bank_state_t          bank_state_next [2];
    rd_state_t            rd_state_reg, rd_state_next;
    logic                 wr_bank_reg, wr_bank_next;
    logic                 rd_bank_reg, rd_bank_next;
    logic [FFT_LOG2N-1:0] rd_cnt_reg, rd_cnt_next;
    logic                 ovf_reg, ovf_next;

    logic                 xfer, rel_bank, capture, drop;
    logic [1:0]           bank_we;
    logic [FFT_LOG2N-1:0] rd_pos;
    logic [DATA_W-1:0]    bank_re [2];
    logic [DATA_W-1:0]    bank_im [2];

    assign rd_pos = (BITREV_OUT != 0) ? bitrev3(rd_cnt_reg) : rd_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_we[gi] = capture && (wr_bank_reg == 1'(gi));

            fft8_frame_bank #(
                .DATA_W (DATA_W)
            ) u_bank (
                .clk    (clk),
                .we     (bank_we[gi]),
                .wr_re  (cap_re),
                .wr_im  (cap_im),
                .rd_idx (rd_pos),
                .rd_re  (bank_re[gi]),
                .rd_im  (bank_im[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state_reg[0] <= BANK_EMPTY;
            bank_state_reg[1] <= BANK_EMPTY;
            rd_state_reg      <= RD_IDLE;
            wr_bank_reg       <= 1'b0;
            rd_bank_reg       <= 1'b0;
            rd_cnt_reg        <= '0;
            ovf_reg           <= 1'b0;
        end else begin
            bank_state_reg    <= bank_state_next;
            rd_state_reg      <= rd_state_next;
            wr_bank_reg       <= wr_bank_next;
            rd_bank_reg       <= rd_bank_next;
            rd_cnt_reg        <= rd_cnt_next;
            ovf_reg           <= ovf_next;
        end
    end

    always_comb begin
        bank_state_next = bank_state_reg;
        rd_state_next   = rd_state_reg;
        wr_bank_next    = wr_bank_reg;
        rd_bank_next    = rd_bank_reg;
        rd_cnt_next     = rd_cnt_reg;
        ovf_next        = ovf_reg;

        xfer     = (rd_state_reg == RD_STREAM) && m.m_ready_i;
        rel_bank = xfer && (rd_cnt_reg == 3'(FFT_N - 1));
        // A bank draining its last beat this cycle can be refilled at the same
        // edge; the pointers only coincide when both banks are full.
        capture  = valid_i && ((bank_state_reg[wr_bank_reg] == BANK_EMPTY) ||
                               (rel_bank && (rd_bank_reg == wr_bank_reg)));
        drop     = valid_i && !capture;

        if (xfer) begin
            rd_cnt_next = rd_cnt_reg + 3'd1;    // wraps to 0 after the 8th beat
        end
        if (rel_bank) begin
            bank_state_next[rd_bank_reg] = BANK_EMPTY;
            rd_bank_next                 = ~rd_bank_reg;
        end
        // Applied after the release so a same-bank refill leaves it FULL.
        if (capture) begin
            bank_state_next[wr_bank_reg] = BANK_FULL;
            wr_bank_next                 = ~wr_bank_reg;
        end

        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_next = 1'b0;
        end

        // Streaming follows the occupancy of whichever bank is read next,
        // so a full second bank continues without a bubble.
        rd_state_next = (bank_state_next[rd_bank_next] == BANK_FULL) ? RD_STREAM : RD_IDLE;
    end

    assign m.m_valid_o = (rd_state_reg == RD_STREAM);
    assign m.m_idx_o   = rd_pos;
    assign m.m_re_o    = m.m_valid_o ? bank_re[rd_bank_reg] : '0;
    assign m.m_im_o    = m.m_valid_o ? bank_im[rd_bank_reg] : '0;
    assign m.m_last_o  = m.m_valid_o && (rd_cnt_reg == 3'(FFT_N - 1));

    assign busy_o = (bank_state_reg[0] == BANK_FULL) || (bank_state_reg[1] == BANK_FULL);
    assign ovf_o  = ovf_reg;

endmodule

// File: tb/tb_fft8_result_streamer.sv
// Directed bench for fft8_result_streamer: in-order instance (dut) and a
// bit-reversed instance (dut_br). Frame "base b" holds re=b+k, im=-(b+k).
module tb_fft8_result_streamer;
    import fft8_result_streamer_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_a = 1'b0;
    logic          valid_b = 1'b0;
    logic          ready_a = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] xr [8];
    logic [DW-1:0] xi [8];
    logic          busy_a, ovf_a, busy_b, ovf_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft8_result_streamer_if #(.DATA_W(DW)) s_a ();
    fft8_result_streamer_if #(.DATA_W(DW)) s_b ();

    assign s_a.m_ready_i = ready_a;
    assign s_b.m_ready_i = 1'b1;

    fft8_result_streamer #(.DATA_W(DW), .BITREV_OUT(0)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_a),
        .X_0_R_i(xr[0]), .X_0_I_i(xi[0]), .X_1_R_i(xr[1]), .X_1_I_i(xi[1]),
        .X_2_R_i(xr[2]), .X_2_I_i(xi[2]), .X_3_R_i(xr[3]), .X_3_I_i(xi[3]),
        .X_4_R_i(xr[4]), .X_4_I_i(xi[4]), .X_5_R_i(xr[5]), .X_5_I_i(xi[5]),
        .X_6_R_i(xr[6]), .X_6_I_i(xi[6]), .X_7_R_i(xr[7]), .X_7_I_i(xi[7]),
        .m(s_a), .busy_o(busy_a), .ovf_o(ovf_a), .ovf_clr_i(ovf_clr)
    );

    fft8_result_streamer #(.DATA_W(DW), .BITREV_OUT(1)) dut_br (
        .clk(clk), .rst(rst), .valid_i(valid_b),
        .X_0_R_i(xr[0]), .X_0_I_i(xi[0]), .X_1_R_i(xr[1]), .X_1_I_i(xi[1]),
        .X_2_R_i(xr[2]), .X_2_I_i(xi[2]), .X_3_R_i(xr[3]), .X_3_I_i(xi[3]),
        .X_4_R_i(xr[4]), .X_4_I_i(xi[4]), .X_5_R_i(xr[5]), .X_5_I_i(xi[5]),
        .X_6_R_i(xr[6]), .X_6_I_i(xi[6]), .X_7_R_i(xr[7]), .X_7_I_i(xi[7]),
        .m(s_b), .busy_o(busy_b), .ovf_o(ovf_b), .ovf_clr_i(1'b0)
    );

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base);
        for (int k = 0; k < 8; k++) begin
            xr[k] = 16'(base + k);
            xi[k] = 16'(-(base + k));
        end
    endtask

    task automatic pulse_a();
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
    endtask

    // Drains nframes frames from dut, checking order, data, m_last_o and
    // stability under backpressure. ready_mode 0: always ready; 1: ready
    // 1,0,0 repeating. pulse_at >= 0 raises valid_a in the cycle the beat
    // with that running number is presented.
    task automatic run_stream(input string tag, input int nframes,
                              input int b0, input int b1, input int b2,
                              input int ready_mode, input int pulse_at,
                              input int max_cycles);
        int            bases [3];
        int            got;
        int            f;
        int            k;
        bit            held;
        bit            pulsed;
        logic [DW-1:0] h_re, h_im;
        logic [2:0]    h_idx;
        logic          h_last;
        bases  = '{b0, b1, b2};
        got    = 0;
        held   = 1'b0;
        pulsed = 1'b0;
        for (int cyc = 0; cyc < max_cycles && got < nframes * 8; cyc++) begin
            ready_a = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (pulse_at >= 0 && !pulsed && got == pulse_at) begin
                valid_a = 1'b1;
                pulsed  = 1'b1;
            end
            @(negedge clk);
            if (held) begin
                check({tag, " hold valid"}, s_a.m_valid_o, 1);
                check({tag, " hold re"},    s_a.m_re_o,    h_re);
                check({tag, " hold im"},    s_a.m_im_o,    h_im);
                check({tag, " hold idx"},   s_a.m_idx_o,   h_idx);
                check({tag, " hold last"},  s_a.m_last_o,  h_last);
            end
            if (s_a.m_valid_o && ready_a) begin
                f = got / 8;
                k = got % 8;
                $display("%s beat %0d: idx=%0d re=%0d im=%0d last=%0d", tag, got,
                         s_a.m_idx_o, $signed(s_a.m_re_o), $signed(s_a.m_im_o), s_a.m_last_o);
                check({tag, " idx"},  s_a.m_idx_o,          k);
                check({tag, " re"},   $signed(s_a.m_re_o),  bases[f] + k);
                check({tag, " im"},   $signed(s_a.m_im_o),  -(bases[f] + k));
                check({tag, " last"}, s_a.m_last_o,         (k == 7) ? 1 : 0);
                got++;
            end
            held   = s_a.m_valid_o && !ready_a;
            h_re   = s_a.m_re_o;
            h_im   = s_a.m_im_o;
            h_idx  = s_a.m_idx_o;
            h_last = s_a.m_last_o;
            tick();
            valid_a = 1'b0;
        end
        check({tag, " beat count"}, got, nframes * 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [8];
        seq = '{0, 4, 2, 6, 1, 5, 3, 7};
        load_frame(0);

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst valid", s_a.m_valid_o, 0);
        check("rst last",  s_a.m_last_o,  0);
        check("rst idx",   s_a.m_idx_o,   0);
        check("rst re",    s_a.m_re_o,    0);
        check("rst im",    s_a.m_im_o,    0);
        check("rst busy",  busy_a,        0);
        check("rst ovf",   ovf_a,         0);
        check("rst br valid", s_b.m_valid_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame, ready held high: beats start the cycle after capture
        load_frame(1);
        ready_a = 1'b1;
        pulse_a();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            $display("single beat %0d: idx=%0d re=%0d im=%0d last=%0d", i,
                     s_a.m_idx_o, $signed(s_a.m_re_o), $signed(s_a.m_im_o), s_a.m_last_o);
            check("single valid", s_a.m_valid_o, 1);
            check("single idx",   s_a.m_idx_o,   i);
            check("single re",    $signed(s_a.m_re_o), i + 1);
            check("single im",    $signed(s_a.m_im_o), -(i + 1));
            check("single last",  s_a.m_last_o, (i == 7) ? 1 : 0);
            check("single busy",  busy_a, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("single end valid", s_a.m_valid_o, 0);
        check("single end busy",  busy_a, 0);
        @(posedge clk); #1;

        // Backpressure: ready 1,0,0 repeating
        ready_a = 1'b0;
        load_frame(20);
        pulse_a();
        run_stream("bp", 1, 20, 0, 0, 1, -1, 100);
        @(negedge clk);
        check("bp end valid", s_a.m_valid_o, 0);
        check("bp end busy",  busy_a, 0);
        @(posedge clk); #1;

        // Overflow: A, B stored, C dropped
        ready_a = 1'b0;
        load_frame(40); pulse_a();
        load_frame(60); pulse_a();
        load_frame(80); pulse_a();
        @(negedge clk);
        check("ovf flag",  ovf_a, 1);
        check("ovf busy",  busy_a, 1);
        check("ovf head re", $signed(s_a.m_re_o), 40);
        @(posedge clk); #1;
        run_stream("ovf", 2, 40, 60, 0, 0, -1, 100);
        @(negedge clk);
        check("ovf sticky",    ovf_a, 1);
        check("ovf end valid", s_a.m_valid_o, 0);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf cleared", ovf_a, 0);
        @(posedge clk); #1;

        // Simultaneous release of A and capture of C into the same bank
        ready_a = 1'b0;
        load_frame(40); pulse_a();
        load_frame(60); pulse_a();
        load_frame(80);
        run_stream("simul", 3, 40, 60, 80, 0, 7, 100);
        @(negedge clk);
        check("simul ovf",  ovf_a, 0);
        check("simul busy", busy_a, 0);
        @(posedge clk); #1;

        // Reset mid-stream after 3 beats
        load_frame(10);
        ready_a = 1'b1;
        pulse_a();
        repeat (3) tick();
        @(negedge clk);
        check("midrst pre idx", s_a.m_idx_o, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst valid", s_a.m_valid_o, 0);
        check("midrst busy",  busy_a, 0);
        check("midrst idx",   s_a.m_idx_o, 0);
        @(posedge clk); #1;
        load_frame(30);
        pulse_a();
        run_stream("midrst", 1, 30, 0, 0, 0, -1, 100);

        // Bit-reversed output order on dut_br
        load_frame(100);
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            $display("bitrev beat %0d: idx=%0d re=%0d im=%0d last=%0d", i,
                     s_b.m_idx_o, $signed(s_b.m_re_o), $signed(s_b.m_im_o), s_b.m_last_o);
            check("bitrev valid", s_b.m_valid_o, 1);
            check("bitrev idx",   s_b.m_idx_o,   seq[i]);
            check("bitrev re",    $signed(s_b.m_re_o), 100 + seq[i]);
            check("bitrev im",    $signed(s_b.m_im_o), -(100 + seq[i]));
            check("bitrev last",  s_b.m_last_o, (i == 7) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bitrev end valid", s_b.m_valid_o, 0);
        check("bitrev end busy",  busy_b, 0);
        check("bitrev ovf",       ovf_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft8_result_streamer.md
Name: fft8_result_streamer

Overview:
Downstream stage of the 8-point FFT datapath. It captures the 8 complex results (16 x 16-bit words) presented in parallel by the datapath on its done strobe, then emits them one bin per beat on a valid/ready stream toward the output interface. Two frame banks (ping-pong) let the datapath finish frame N+1 while frame N is still draining. Overflow is flagged, never silent.

Parameters:
DATA_W, 16, width of each real/imag word (signed, two's complement)
BITREV_OUT, 0, 0 = emit bins in order 0..7; 1 = emit in bit-reversed order 0,4,2,6,1,5,3,7

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_i  in  1  one-cycle pulse: datapath results valid this cycle
X_k_R_i (k=0..7)  in  DATA_W each  real part of bin k
X_k_I_i (k=0..7)  in  DATA_W each  imag part of bin k
m_valid_o  out  1  stream beat valid
m_ready_i  in  1  downstream accepts beat
m_re_o  out  DATA_W  real part of current beat
m_im_o  out  DATA_W  imag part of current beat
m_idx_o  out  3  bin index k of current beat
m_last_o  out  1  high on the 8th beat of a frame
busy_o  out  1  at least one bank full
ovf_o  out  1  sticky: a frame was dropped
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset: m_valid_o=0, m_last_o=0, m_idx_o=0, m_re_o/m_im_o=0, busy_o=0, ovf_o=0; both banks EMPTY; wr_bank=0, rd_bank=0, rd_cnt=0. Reset mid-stream aborts the frame and discards both banks.
- Bank state per bank: EMPTY/FULL. Read FSM: IDLE (rd bank EMPTY) / STREAM (rd bank FULL).
- Capture: valid_i high and bank[wr_bank] EMPTY -> all 16 words are written into bank[wr_bank] at that clock edge; the bank becomes FULL and wr_bank toggles.
- Capture with bank[wr_bank] FULL and no release in the same cycle -> frame dropped; no bank or pointer changes; ovf_o set to 1 on the next edge.
- Simultaneous release (final beat handshake of bank X) and capture into the same bank X -> capture is accepted; bank X stays FULL with the new data; rd_bank and wr_bank both toggle.
- Latency: valid_i at edge t -> m_valid_o=1 after edge t (visible in cycle t+1) when the read FSM was IDLE.
- Beat: m_valid_o = FULL[rd_bank]. m_re_o/m_im_o/m_idx_o are driven from bank[rd_bank] at position p = rd_cnt (BITREV_OUT=0) or bitrev3(rd_cnt) (BITREV_OUT=1); m_idx_o = p; m_last_o = m_valid_o & (rd_cnt==7).
- Handshake: a transfer occurs when m_valid_o & m_ready_i. rd_cnt increments on a transfer. On a transfer with rd_cnt==7: rd_cnt=0, bank[rd_bank] becomes EMPTY, rd_bank toggles. If the other bank is FULL, streaming continues with no bubble cycle.
- While m_valid_o=1 and m_ready_i=0, all m_* outputs are held stable (AXI-stream rule). m_valid_o never drops without a transfer.
- Words pass through unmodified: no scaling, no saturation.
- ovf_o: set by a drop, cleared by ovf_clr_i. If a drop and ovf_clr_i occur in the same cycle, set wins.
- busy_o = FULL[0] | FULL[1].

Decomposition:
- Shared constants header (alongside the existing FFT constants): FFT_N=8, FFT_LOG2N=3, and a bitrev3 function/macro.
- Natural sub-module: fft8_frame_bank. It holds one 8 x (2*DATA_W) register bank, with a write-all port (we, 16 words) and a combinational read port (idx -> re, im). It is instantiated twice; the top holds the FSM, the pointers and the overflow logic.

Test Plan:
- Single frame, m_ready_i=1, X_k_R=k+1 and X_k_I=-(k+1), valid_i at cycle 10 -> beats in cycles 11..18 with idx 0..7, re=1..8, im=-1..-8; m_last_o only in cycle 18; busy_o falls after cycle 18.
- Backpressure: m_ready_i toggling 1,0,0,1,... -> every beat is held stable while ready=0; exactly 8 transfers; data order intact; no duplicates.
- Overflow: m_ready_i=0, three valid_i pulses with frames A, B, C -> A and B are stored, C is dropped, ovf_o=1; with m_ready_i raised afterwards, 16 beats A0..A7 then B0..B7; ovf_clr_i -> ovf_o=0.
- Simultaneous release/capture: both banks full, with a valid_i pulse in the same cycle as A's 8th handshake -> ovf_o stays 0; output is B0..B7 then C0..C7.
- Reset mid-stream after 3 beats -> next cycle m_valid_o=0 and busy_o=0; a new frame streams from idx 0.
- BITREV_OUT=1 with bin k holding value 100+k -> m_idx_o sequence 0,4,2,6,1,5,3,7 with re = 100 + m_idx_o.
